// File: rtl/data_memory_arbiter_pkg.sv
// data_mem_arb_pkg: owner encoding, strobe constants and default width for the data memory arbiter
package data_mem_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_e;
  localparam logic [3:0] STRB_ALL = 4'hF;
  localparam logic [3:0] STRB_NONE = 4'h0;
  localparam int ADDR_W = 30;
endpackage

// File: rtl/data_memory_arbiter_if.sv
// data_memory_arbiter_if: fetch, load/store and SRAM port signals shared through the arbiter
interface data_memory_arbiter_if #(parameter int ADDR_W = data_mem_arb_pkg::ADDR_W);
  logic              flush;
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;
  logic              ls_req_valid;
  logic              ls_req_ready;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [3:0]        ls_req_ce;
  logic [3:0]        ls_req_we;
  logic [31:0]       ls_req_d;
  logic              ls_rsp_valid;
  logic [31:0]       ls_rsp_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_ce;
  logic [3:0]        mem_we;
  logic [31:0]       mem_d;
  logic [31:0]       mem_q;
  modport slave (
    input  flush, if_req_valid, if_req_addr, ls_req_valid, ls_req_addr, ls_req_ce, ls_req_we, ls_req_d, mem_q,
    output if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid, ls_rsp_data,
           mem_addr, mem_ce, mem_we, mem_d
  );
  modport master (
    output flush, if_req_valid, if_req_addr, ls_req_valid, ls_req_addr, ls_req_ce, ls_req_we, ls_req_d, mem_q,
    input  if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid, ls_rsp_data,
           mem_addr, mem_ce, mem_we, mem_d
  );
endinterface

// File: rtl/data_memory_arbiter_starve_ctr.sv
// arb_starve_ctr: counts cycles a waiting fetch loses arbitration; ovr lets it win once saturated
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic if_valid,
    input  logic if_grant,
    output logic ovr
);
  localparam int W = $clog2(STARVE_MAX + 1);
  localparam logic [W-1:0] MAX = W'(STARVE_MAX);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (!if_valid || if_grant) cnt <= '0;
    else if (!flush && cnt != MAX) cnt <= cnt + 1'b1;
  end
  assign ovr = cnt == MAX;
endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one sync-read SRAM between fetch and load/store, LS priority.
// ARB_STARVE_GUARD_EN adds a starvation guard that lets a stalled fetch win after STARVE_MAX losses.
module data_memory_arbiter
  import data_mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input logic clk,
    input logic reset,
    data_memory_arbiter_if.slave bus
);
  owner_e owner;
  logic ovr, if_pend, ls_pend;
`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve_ctr (
      .clk(clk),
      .reset(reset),
      .flush(bus.flush),
      .if_valid(bus.if_req_valid),
      .if_grant(bus.if_req_ready),
      .ovr(ovr)
  );
`else
  logic starve_unused;
  assign ovr = 1'b0;
  assign starve_unused = STARVE_MAX > 0;
`endif
  always_comb begin
    owner = reset ? OWN_NONE
          : (bus.if_req_valid && !bus.flush && (!bus.ls_req_valid || ovr)) ? OWN_IF
          : bus.ls_req_valid ? OWN_LS : OWN_NONE;
    bus.mem_addr = owner == OWN_IF ? bus.if_req_addr : owner == OWN_LS ? bus.ls_req_addr : '0;
    bus.mem_ce = owner == OWN_IF ? STRB_ALL : owner == OWN_LS ? bus.ls_req_ce : STRB_NONE;
    bus.mem_we = (owner == OWN_LS && !bus.flush) ? bus.ls_req_we : STRB_NONE;
    bus.mem_d = owner == OWN_LS ? bus.ls_req_d : '0;
  end
  assign bus.if_req_ready = owner == OWN_IF;
  assign bus.ls_req_ready = owner == OWN_LS;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_pend <= 1'b0;
      ls_pend <= 1'b0;
    end else begin
      if_pend <= owner == OWN_IF;
      ls_pend <= owner == OWN_LS && |bus.ls_req_ce && ~|bus.ls_req_we && !bus.flush;
    end
  end
  // a flush in the response cycle kills the in-flight fetch only
  assign bus.if_rsp_valid = if_pend && !bus.flush;
  assign bus.ls_rsp_valid = ls_pend;
  assign bus.if_rsp_data = bus.if_rsp_valid ? bus.mem_q : '0;
  assign bus.ls_rsp_data = bus.ls_rsp_valid ? bus.mem_q : '0;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed self-checking bench for data_memory_arbiter
module tb_data_memory_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  bit prev_ls;
  bit exp_if;
  data_memory_arbiter_if #(.ADDR_W(30)) bus ();
  data_memory_arbiter #(.STARVE_MAX(4)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic idle();
    bus.flush = 1'b0;
    bus.if_req_valid = 1'b0;
    bus.if_req_addr = '0;
    bus.ls_req_valid = 1'b0;
    bus.ls_req_addr = '0;
    bus.ls_req_ce = 4'h0;
    bus.ls_req_we = 4'h0;
    bus.ls_req_d = '0;
    bus.mem_q = '0;
  endtask
  task automatic ifr(input logic [29:0] a);
    bus.if_req_valid = 1'b1;
    bus.if_req_addr = a;
  endtask
  task automatic lsr(input logic [29:0] a, input logic [3:0] ce, input logic [3:0] we, input logic [31:0] d);
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr = a;
    bus.ls_req_ce = ce;
    bus.ls_req_we = we;
    bus.ls_req_d = d;
  endtask
  initial begin
    idle();
    ifr(30'h10);
    lsr(30'h5, 4'hF, 4'h0, 32'h0);
    #1;
    chk("rst_if_ready", bus.if_req_ready, 0);
    chk("rst_ls_ready", bus.ls_req_ready, 0);
    chk("rst_mem_ce", bus.mem_ce, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    @(negedge clk);
    #1;
    chk("rst_if_rsp", bus.if_rsp_valid, 0);
    chk("rst_ls_rsp", bus.ls_rsp_valid, 0);
    chk("rst_ls_data", bus.ls_rsp_data, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ls_ready", bus.ls_req_ready, 1);
    chk("post_rst_if_ready", bus.if_req_ready, 0);
    // IF-only fetch, data returned next cycle
    @(negedge clk);
    idle();
    ifr(30'h10);
    #1;
    chk("if_ready", bus.if_req_ready, 1);
    chk("if_mem_ce", bus.mem_ce, 32'hF);
    chk("if_mem_addr", bus.mem_addr, 32'h10);
    chk("if_mem_we", bus.mem_we, 0);
    @(negedge clk);
    idle();
    bus.mem_q = 32'hDEADBEEF;
    #1;
    chk("if_rsp_valid", bus.if_rsp_valid, 1);
    chk("if_rsp_data", bus.if_rsp_data, 32'hDEADBEEF);
    chk("if_ls_rsp_quiet", bus.ls_rsp_valid, 0);
    @(negedge clk);
    idle();
    bus.mem_q = 32'hDEADBEEF;
    #1;
    chk("if_rsp_drop", bus.if_rsp_valid, 0);
    chk("if_rsp_data_zero", bus.if_rsp_data, 0);
    chk("idle_mem_ce", bus.mem_ce, 0);
    // both valid: LS byte store wins
    @(negedge clk);
    idle();
    ifr(30'h44);
    lsr(30'h20, 4'b0010, 4'b0010, 32'h0000AB00);
    #1;
    chk("sb_ls_ready", bus.ls_req_ready, 1);
    chk("sb_if_ready", bus.if_req_ready, 0);
    chk("sb_mem_we", bus.mem_we, 32'h2);
    chk("sb_mem_ce", bus.mem_ce, 32'h2);
    chk("sb_mem_addr", bus.mem_addr, 32'h20);
    chk("sb_mem_d", bus.mem_d, 32'h0000AB00);
    @(negedge clk);
    idle();
    #1;
    chk("sb_no_ls_rsp", bus.ls_rsp_valid, 0);
    chk("sb_no_if_rsp", bus.if_rsp_valid, 0);
    chk("idle_mem_addr", bus.mem_addr, 0);
    // alternating LS load / IF fetch, back to back
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle();
      if (i < 4) begin
        if (i % 2 == 0) lsr(30'h30, 4'hF, 4'h0, 32'h0);
        else ifr(30'h31);
      end
      if (i > 0) bus.mem_q = prev_ls ? 32'h30 : 32'h31;
      #1;
      if (i > 0) begin
        chk("alt_ls_rsp", bus.ls_rsp_valid, 32'(prev_ls));
        chk("alt_if_rsp", bus.if_rsp_valid, 32'(!prev_ls));
        chk("alt_rsp_data", prev_ls ? bus.ls_rsp_data : bus.if_rsp_data, prev_ls ? 32'h30 : 32'h31);
      end
      if (i < 4) chk("alt_ready", i % 2 == 0 ? bus.ls_req_ready : bus.if_req_ready, 1);
      prev_ls = i % 2 == 0;
    end
    // flush handling
    @(negedge clk);
    idle();
    ifr(30'h50);
    #1;
    chk("fl_if_ready", bus.if_req_ready, 1);
    @(negedge clk);
    idle();
    bus.flush = 1'b1;
    lsr(30'h60, 4'hF, 4'hF, 32'h5555);
    bus.mem_q = 32'h1234;
    #1;
    chk("fl_if_rsp_killed", bus.if_rsp_valid, 0);
    chk("fl_if_rsp_data", bus.if_rsp_data, 0);
    chk("fl_sw_ls_ready", bus.ls_req_ready, 1);
    chk("fl_sw_mem_we", bus.mem_we, 0);
    chk("fl_sw_mem_ce", bus.mem_ce, 32'hF);
    chk("fl_sw_mem_addr", bus.mem_addr, 32'h60);
    @(negedge clk);
    idle();
    bus.flush = 1'b1;
    ifr(30'h70);
    #1;
    chk("fl_if_only_ready", bus.if_req_ready, 0);
    chk("fl_if_only_ce", bus.mem_ce, 0);
    chk("fl_sw_no_rsp", bus.ls_rsp_valid, 0);
    @(negedge clk);
    idle();
    bus.flush = 1'b1;
    lsr(30'h61, 4'hF, 4'h0, 32'h0);
    #1;
    chk("fl_lw_ready", bus.ls_req_ready, 1);
    @(negedge clk);
    idle();
    bus.mem_q = 32'h99;
    #1;
    chk("fl_lw_no_rsp", bus.ls_rsp_valid, 0);
    chk("fl_if_no_rsp", bus.if_rsp_valid, 0);
    @(negedge clk);
    idle();
    lsr(30'h62, 4'hF, 4'h0, 32'h0);
    @(negedge clk);
    idle();
    bus.flush = 1'b1;
    bus.mem_q = 32'hAA;
    #1;
    chk("fl_ls_rsp_kept", bus.ls_rsp_valid, 1);
    chk("fl_ls_rsp_data", bus.ls_rsp_data, 32'hAA);
    // continuous contention: guard build rotates every 5th grant to IF
    @(negedge clk);
    idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      idle();
      ifr(30'h80);
      lsr(30'h81, 4'hF, 4'h0, 32'h0);
      #1;
`ifdef ARB_STARVE_GUARD_EN
      exp_if = i % 5 == 4;
`else
      exp_if = 1'b0;
`endif
      chk("starve_if_ready", bus.if_req_ready, 32'(exp_if));
      chk("starve_ls_ready", bus.ls_req_ready, 32'(!exp_if));
    end
    @(negedge clk);
    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
